// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide unit.
package mdu_pkg;
    localparam int MDU_ITER  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITER);

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mdu_state_e;
endpackage

// File: rtl/mdu_datapath.sv
// Magnitude datapath: shift-add multiply / restoring divide over one 2*WIDTH accumulator.
// MDU_FAST_MULT_EN: multiplies load the full product directly at start.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    // Divide: high half is the partial remainder, low half dividend bits turning into quotient.
    assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = {1'b0, trial} - {2'b00, b_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            b_q <= '0;
        end else if (load) begin
            b_q <= b;
`ifdef MDU_FAST_MULT_EN
            if (!is_div) acc <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
            else         acc <= {{WIDTH{1'b0}}, a};
`else
            acc <= {{WIDTH{1'b0}}, a};
`endif
        end else if (step) begin
            if (!is_div)
                acc <= {mul_sum, acc[WIDTH-1:1]};
            else if (!diff[WIDTH+1])
                acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: control FSM, sign fix-up and architectural HI/LO.
// MDU_FAST_MULT_EN: MULT/MULTU skip the iterative CALC phase.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_e           state;
    logic [MDU_CNT_W-1:0] cnt;
    logic                 div_q, neg_q, neg_r, dz_q;

    logic                 signed_op, op_div, rs_neg, rt_neg, load, dp_div;
    logic [WIDTH-1:0]     rs_mag, rt_mag, quo, rem;
    logic [2*WIDTH-1:0]   acc;

    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_data : rs_data;
    assign rt_mag    = rt_neg ? -rt_data : rt_data;
    assign load      = (state == IDLE) && start;
    assign dp_div    = (state == IDLE) ? op_div : div_q;
    assign quo       = acc[WIDTH-1:0];
    assign rem       = acc[2*WIDTH-1:WIDTH];

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (state == CALC),
        .is_div (dp_div),
        .a      (rs_mag),
        .b      (rt_mag),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        div_q <= op_div;
                        neg_q <= rs_neg ^ rt_neg;
                        neg_r <= rs_neg;
                        dz_q  <= (rt_data == '0);
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                        state <= op_div ? CALC : FINISH;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (cnt == MDU_CNT_W'(MDU_ITER - 1)) state <= FINISH;
                    else                                 cnt   <= cnt + 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    // Divide-by-zero remainder already equals the signed dividend after fix-up.
                    if (div_q) begin
                        lo <= dz_q ? '1 : (neg_q ? -quo : quo);
                        hi <= neg_r ? -rem : rem;
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a cycle-level reference model of HI/LO, busy and done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI,LO} straight from the arithmetic definition.
    function automatic logic [63:0] golden(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint q, r;
        case (o)
            MDU_MULT:  return sa * sb;
            MDU_MULTU: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == MDU_DIV) begin q = sa / sb; r = sa % sb; end
                else              begin q = ua / ub; r = ua % ub; end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int lat(logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
        return o[1] ? 33 : 1;
`else
        return (o == 2'b00) ? 33 : 33;
`endif
    endfunction

    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_rem <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start) begin
                    m_rem <= lat(op);
                    {p_hi, p_lo} <= golden(op, rs_data, rt_data);
                end
            end else if (m_rem == 1) begin
                m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_rem != 0});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic launch(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int exp_lat);
        int n = 0;
        bit got = 1'b0;
        while (n < 60 && !got) begin
            @(posedge clk); #1;
            n++;
            got = done;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end else begin
            chk({name, "_lat"}, n, exp_lat);
        end
    endtask

    task automatic do_op(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                         logic [31:0] ehi, logic [31:0] elo);
        launch(o, a, b);
        wait_done(name, lat(o));
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; rs_data = '0; rt_data = '0; wdata = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);

        do_op("multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_neg",    MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_negneg", MDU_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'h0,         32'h0000_000A);
        do_op("div_neg",     MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_negdvs",  MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
        do_op("div_ovf",     MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        do_op("divu_zero",   MDU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        do_op("div_zero_neg",MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
        do_op("divu_big",    MDU_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);

        // MTHI in idle, then a DIVU with a stray start and MTLO mid-operation.
        hi_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h55);
        chk("mthi_lo", lo, 32'h1999_9999);
        launch(MDU_DIVU, 32'd9, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = MDU_MULT; rs_data = 32'd3; rt_data = 32'd3;
        lo_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        chk("ignored_lo", lo, 32'h1999_9999);
        wait_done("divu_guard", 27);
        chk("divu_guard_hi", hi, 32'h1);
        chk("divu_guard_lo", lo, 32'h2);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mtboth_hi", hi, 32'hA5A5_A5A5);
        chk("mtboth_lo", lo, 32'hA5A5_A5A5);

        // MTLO landing on the same edge as start, later overwritten by the result.
        lo_we = 1'b1; wdata = 32'h1234;
        launch(MDU_MULTU, 32'd2, 32'd3);
        lo_we = 1'b0;
        chk("start_mtlo_lo", lo, 32'h1234);
        wait_done("multu_small", lat(MDU_MULTU));
        chk("multu_small_hi", hi, 32'h0);
        chk("multu_small_lo", lo, 32'h6);

        // Abort a DIVU with reset partway through.
        launch(MDU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);

        do_op("post_abort", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of `register_file` and takes the rs/rt operands from `read_data_1`/`read_data_2`. It executes MULT, MULTU, DIV and DIVU, holds the architectural HI and LO registers, and serves MTHI/MTLO writes and MFHI/MFLO reads. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  WIDTH  multiplicand or dividend (from `read_data_1`).
- `rt_data`  in  WIDTH  multiplier or divisor (from `read_data_2`).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO updated with a result.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO, registered.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: `WIDTH` iterations; a 5-bit counter runs 0..31.
  - FINISH: sign fix-up, HI/LO write.
- Transitions: IDLE→CALC on `start`; CALC→FINISH when the counter reaches 31; FINISH→IDLE unconditionally.
- Start handling: on `start` the unit latches `op`. For signed ops it latches the operand magnitudes and the result signs.
- Multiply: shift-add over a 2·WIDTH accumulator. Result {HI,LO} is the full 64-bit product.
- Divide: restoring division on magnitudes.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the dividend's sign.
- Divide by zero: LO = all ones, HI = `rs_data` as latched. Still takes the full latency.
- Signed overflow 0x80000000 / −1: LO = 0x80000000, HI = 0.
- MTHI/MTLO: take effect only in IDLE and FINISH-free cycles. Ignored while `busy`=1 (stall is the pipeline's job).
  - If `start` coincides with a write in IDLE, the write lands at that edge and the result later overwrites it.
  - `hi_we` and `lo_we` may both be asserted; both registers load `wdata`.
- `start` while `busy`=1: ignored, no effect on the running operation.

## Timing
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `start` sampled at edge T.
- `busy`=1 after edges T..T+32 and drops after edge T+33.
- HI/LO are written and `done`=1 after edge T+33, for exactly one cycle.
- Back-to-back: a new `start` is accepted at edge T+33+1 at the earliest, i.e. the first cycle `busy`=0.
- Reset asserted mid-operation: aborts the operation at that edge. All outputs return to reset values, and the partial result is discarded.
- `hi`/`lo` change only at MTHI/MTLO edges, FINISH, or reset.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU bypass CALC: IDLE→FINISH using a single-cycle `*` product.
  - `busy`=1 for one cycle; result and `done` appear after edge T+1.
  - DIV/DIVU are unchanged.
- Undefined: all four ops use the 33-cycle iterative path, and no hardware multiplier is inferred.

## Structure
- Package `mdu_pkg`:
  - op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - FSM state enum
  - `MDU_ITER` = 32 and iteration-counter width
- One sub-module, `mdu_datapath`: accumulator/remainder/quotient registers and the per-iteration shift-add / trial-subtract.
- The FSM, sign fix-up and HI/LO registers stay in `mult_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` after edge T+33, `busy` high for 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. With `MDU_FAST_MULT_EN` the same result appears after edge T+1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100, full latency.
- MTHI 0x55 in IDLE → `hi`=0x55 next cycle. Then start DIVU 9/4, pulse `start` with op=MULT and assert `lo_we` mid-operation → both ignored; final HI=1, LO=2.
- Reset asserted at cycle 10 of a DIVU → `busy`=0, `done`=0, `hi`=`lo`=0 next cycle. No `done` pulse follows.
